// File: rtl/ysyx_25020037_hazard_ctrl_pkg.sv
// Shared definitions for the decode/execute issue controller.
// Writeback forwarding is enabled by defining YSYX_25020037_HC_BYPASS_EN.
package ysyx_25020037_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HC_RUN    = 2'd0,
    HC_DRAIN  = 2'd1,
    HC_SERIAL = 2'd2
  } hc_state_e;

  localparam int HC_CNT_W = 2;
  localparam int HC_TOT_W = 4;

endpackage

// File: rtl/ysyx_25020037_sb_cnt.sv
// Saturating up/down pending-write counter for one GPR.
// err flags a decrement requested while the count is already zero.
module ysyx_25020037_sb_cnt
  import ysyx_25020037_hazard_ctrl_pkg::*;
#(
  parameter int W = HC_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  logic [W-1:0] cnt_nxt;

  assign err = dec & (cnt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (inc & ~dec & (cnt != '1))
      cnt_nxt = cnt + W'(1);
    else if (dec & ~inc & (cnt != '0))
      cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ysyx_25020037_hazard_ctrl.sv
// Decode-to-execute issue controller: GPR scoreboard, RAW stalls and serialization FSM.
// Define YSYX_25020037_HC_BYPASS_EN to waive hazards resolved by a same-cycle writeback.
module ysyx_25020037_hazard_ctrl
  import ysyx_25020037_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = HC_CNT_W,
  parameter int TOT_W = HC_TOT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       du_valid,
  input  logic [4:0] du_rs1,
  input  logic [4:0] du_rs2,
  input  logic       du_rs1_used,
  input  logic       du_rs2_used,
  input  logic [4:0] du_rd,
  input  logic       du_gpr_we,
  input  logic       du_serial,
  input  logic       exu_ready,
  output logic       issue_ready,
  output logic       issue_fire,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       serial_done,
  input  logic       flush,
  output logic       busy,
  output logic       sb_err
);

  logic [CNT_W-1:0] cnt [32];
  logic [31:1]      inc_vec, dec_vec, err_vec;
  logic [TOT_W-1:0] tot, tot_nxt;
  hc_state_e        state, state_nxt;
  logic             waive1, waive2, raw, ovf, tot_stall, drain_empty;
  logic             inc_tot, dec_tot, busy_nxt;

  assign cnt[0] = '0;

  for (genvar i = 1; i < 32; i++) begin : g_sb
    assign inc_vec[i] = issue_fire & du_gpr_we & (du_rd == 5'(i));
    assign dec_vec[i] = wb_valid & (wb_rd == 5'(i));
    ysyx_25020037_sb_cnt #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc_vec[i]),
      .dec (dec_vec[i]),
      .cnt (cnt[i]),
      .err (err_vec[i])
    );
  end

`ifdef YSYX_25020037_HC_BYPASS_EN
  // The last outstanding write retiring this cycle is forwarded to the reader.
  assign waive1      = wb_valid & (wb_rd == du_rs1) & (cnt[du_rs1] == CNT_W'(1));
  assign waive2      = wb_valid & (wb_rd == du_rs2) & (cnt[du_rs2] == CNT_W'(1));
  assign drain_empty = (tot == '0) | (wb_valid & (tot == TOT_W'(1)));
`else
  assign waive1      = 1'b0;
  assign waive2      = 1'b0;
  assign drain_empty = (tot == '0);
`endif

  assign raw = (du_rs1_used & (cnt[du_rs1] != '0) & ~waive1)
             | (du_rs2_used & (cnt[du_rs2] != '0) & ~waive2);
  assign ovf       = du_gpr_we & (du_rd != 5'd0) & (cnt[du_rd] == '1);
  assign tot_stall = du_gpr_we & (tot == '1);

  always_comb begin
    issue_ready = 1'b0;
    case (state)
      HC_RUN:   issue_ready = ~raw & ~ovf & ~tot_stall & ~du_serial;
      HC_DRAIN: issue_ready = drain_empty & ~raw;
      default:  issue_ready = 1'b0;
    endcase
  end

  assign issue_fire = du_valid & issue_ready & exu_ready & ~flush;

  // A writeback against a zero count is an error and must not touch the total.
  assign inc_tot = issue_fire & du_gpr_we & (du_rd != 5'd0);
  assign dec_tot = wb_valid & (wb_rd != 5'd0) & (cnt[wb_rd] != '0);

  always_comb begin
    tot_nxt = tot;
    if (inc_tot & ~dec_tot)      tot_nxt = tot + TOT_W'(1);
    else if (dec_tot & ~inc_tot) tot_nxt = tot - TOT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HC_RUN:    if (du_valid & du_serial & ~flush) state_nxt = HC_DRAIN;
      HC_DRAIN:  if (flush) state_nxt = HC_RUN;
                 else if (issue_fire) state_nxt = HC_SERIAL;
      HC_SERIAL: if (serial_done) state_nxt = HC_RUN;
      default:   state_nxt = HC_RUN;
    endcase
  end

  assign busy_nxt = (tot_nxt != '0) | (state_nxt != HC_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HC_RUN;
      tot    <= '0;
      busy   <= 1'b0;
      sb_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      tot    <= tot_nxt;
      busy   <= busy_nxt;
      sb_err <= sb_err | (|err_vec);
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_hazard_ctrl.sv
// Self-checking bench for ysyx_25020037_hazard_ctrl against a behavioural scoreboard model.
module tb_ysyx_25020037_hazard_ctrl;

  localparam int CNT_W = 2;
  localparam int TOT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int MAXT  = (1 << TOT_W) - 1;
`ifdef YSYX_25020037_HC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       du_valid, du_rs1_used, du_rs2_used, du_gpr_we, du_serial, exu_ready;
  logic [4:0] du_rs1, du_rs2, du_rd, wb_rd;
  logic       wb_valid, serial_done, flush;
  logic       issue_ready, issue_fire, busy, sb_err;

  ysyx_25020037_hazard_ctrl #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst(rst), .du_valid(du_valid), .du_rs1(du_rs1), .du_rs2(du_rs2),
    .du_rs1_used(du_rs1_used), .du_rs2_used(du_rs2_used), .du_rd(du_rd),
    .du_gpr_we(du_gpr_we), .du_serial(du_serial), .exu_ready(exu_ready),
    .issue_ready(issue_ready), .issue_fire(issue_fire), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .serial_done(serial_done), .flush(flush), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: plain per-register pending counts, a total, and a mode (0 run, 1 drain, 2 serial).
  int mcnt [32];
  int mtot;
  int mst;
  bit merr;
  bit exp_ready, exp_fire, exp_busy;

  task automatic m_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    mtot = 0; mst = 0; merr = 1'b0; exp_busy = 1'b0;
  endtask

  function automatic bit m_ready();
    bit hz;
    hz = 1'b0;
    if (du_rs1_used && mcnt[du_rs1] > 0 &&
        !(BYP && wb_valid && wb_rd == du_rs1 && mcnt[du_rs1] == 1)) hz = 1'b1;
    if (du_rs2_used && mcnt[du_rs2] > 0 &&
        !(BYP && wb_valid && wb_rd == du_rs2 && mcnt[du_rs2] == 1)) hz = 1'b1;
    if (mst == 2) return 1'b0;
    if (mst == 1) return !hz && (mtot == 0 || (BYP && wb_valid && mtot == 1));
    return !hz && !du_serial && !(du_gpr_we && du_rd != 0 && mcnt[du_rd] == MAXC)
           && !(du_gpr_we && mtot == MAXT);
  endfunction

  task automatic m_clock();
    int ir, dr;
    ir = (exp_fire && du_gpr_we && du_rd != 0) ? int'(du_rd) : 0;
    dr = 0;
    if (wb_valid && wb_rd != 0) begin
      if (mcnt[wb_rd] == 0) merr = 1'b1;
      else dr = int'(wb_rd);
    end
    if (!(ir != 0 && ir == dr)) begin
      if (ir != 0) begin mcnt[ir] += 1; mtot += 1; end
      if (dr != 0) begin mcnt[dr] -= 1; mtot -= 1; end
    end
    case (mst)
      0: if (du_valid && du_serial && !flush) mst = 1;
      1: if (flush) mst = 0; else if (exp_fire) mst = 2;
      default: if (serial_done) mst = 0;
    endcase
    exp_busy = (mtot != 0) || (mst != 0);
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit ser, input bit er,
                       input bit wv, input int wr, input bit sd, input bit fl);
    du_valid = v; du_rs1 = 5'(rs1); du_rs1_used = u1; du_rs2 = 5'(rs2); du_rs2_used = u2;
    du_rd = 5'(rd); du_gpr_we = we; du_serial = ser; exu_ready = er;
    wb_valid = wv; wb_rd = 5'(wr); serial_done = sd; flush = fl;
  endtask

  task automatic pre();
    #1;
    exp_ready = m_ready();
    exp_fire  = du_valid && exp_ready && exu_ready && !flush;
  endtask

  task automatic post();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic drain_all();
    int r;
    for (int g = 0; g < 200 && (mtot > 0 || mst != 0); g++) begin
      @(negedge clk);
      r = 0;
      for (int k = 31; k > 0; k--) if (mcnt[k] > 0) r = k;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, r != 0, r, mst == 2, mst == 1);
      pre(); post();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    m_reset();
    #2;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_chk++; if (sb_err !== 1'b0) $display("FAIL reset_sb_err: got %0b want 0", sb_err); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    drive(1, 4, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    pre();
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", issue_ready); else n_pass++;
    n_chk++; if (issue_fire !== 1'b1) $display("FAIL reset_fire: got %0b want 1", issue_fire); else n_pass++;
    post();
  endtask

  task automatic test_raw();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0);
      else        drive(1, 5, 1, 0, 0, 6, 1, 0, 1, c == 3, 5, 0, 0);
      pre();
      n_chk++; if (issue_ready !== exp_ready) $display("FAIL raw_ready c%0d: got %0b want %0b", c, issue_ready, exp_ready); else n_pass++;
      n_chk++; if (issue_fire !== exp_fire) $display("FAIL raw_fire c%0d: got %0b want %0b", c, issue_fire, exp_fire); else n_pass++;
      if (c == 1 || c == 2) begin
        n_chk++; if (issue_ready !== 1'b0) $display("FAIL raw_stall c%0d: got %0b want 0", c, issue_ready); else n_pass++;
      end
      if (c == 3) begin
        n_chk++; if (issue_ready !== BYP) $display("FAIL raw_wb_cycle: got %0b want %0b", issue_ready, BYP); else n_pass++;
      end
      if (c == 4 && !BYP) begin
        n_chk++; if (issue_fire !== 1'b1) $display("FAIL raw_after_wb: got %0b want 1", issue_fire); else n_pass++;
      end
      post();
    end
    drain_all();
    n_chk++; if (busy !== 1'b0) $display("FAIL raw_drained_busy: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_overflow();
    bit want;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 7, 1, 0, 1, c == 5, 7, 0, 0);
      pre();
      want = (c < 3 || c == 6);
      n_chk++; if (issue_ready !== want) $display("FAIL ovf_ready c%0d: got %0b want %0b", c, issue_ready, want); else n_pass++;
      n_chk++; if (issue_fire !== exp_fire) $display("FAIL ovf_fire c%0d: got %0b want %0b", c, issue_fire, exp_fire); else n_pass++;
      post();
      n_chk++; if (busy !== exp_busy) $display("FAIL ovf_busy c%0d: got %0b want %0b", c, busy, exp_busy); else n_pass++;
    end
    drain_all();
  endtask

  task automatic test_serial();
    bit fired;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, c, 1, 0, 1, 0, 0, 0, 0);
      pre(); post();
    end
    fired = 1'b0;
    for (int k = 0; k < 8 && !fired; k++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 8, 1, 1, 1, k == 1 || k == 2, k, 0, 0);
      pre();
      n_chk++; if (issue_ready !== exp_ready) $display("FAIL drain_ready k%0d: got %0b want %0b", k, issue_ready, exp_ready); else n_pass++;
      if (k < 2) begin
        n_chk++; if (issue_fire !== 1'b0) $display("FAIL drain_hold k%0d: got %0b want 0", k, issue_fire); else n_pass++;
      end
      fired = issue_fire;
      post();
    end
    n_chk++; if (!fired) $display("FAIL serial_issue: got no issue want issue within 8 cycles"); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL serial_busy: got %0b want 1", busy); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, k == 3, 0);
      pre();
      n_chk++; if (issue_ready !== (k == 4)) $display("FAIL serial_hold k%0d: got %0b want %0b", k, issue_ready, k == 4); else n_pass++;
      n_chk++; if (issue_fire !== exp_fire) $display("FAIL serial_fire k%0d: got %0b want %0b", k, issue_fire, exp_fire); else n_pass++;
      post();
    end
    drain_all();
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0, 1);
    pre();
    n_chk++; if (issue_fire !== 1'b0) $display("FAIL flush_fire: got %0b want 0", issue_fire); else n_pass++;
    post();
    n_chk++; if (busy !== 1'b0) $display("FAIL flush_counts: busy got %0b want 0", busy); else n_pass++;
    @(negedge clk); drive(1, 0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0, 0); pre(); post();
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); pre(); post();
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1); pre();
    n_chk++; if (issue_fire !== 1'b0) $display("FAIL flush_drain_fire: got %0b want 0", issue_fire); else n_pass++;
    post();
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); pre();
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL flush_to_run: got %0b want 1", issue_ready); else n_pass++;
    n_chk++; if (issue_ready !== exp_ready) $display("FAIL flush_model: got %0b want %0b", issue_ready, exp_ready); else n_pass++;
    post();
    drain_all();
  endtask

  task automatic test_err_x0();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0); pre(); post();
    n_chk++; if (sb_err !== 1'b1) $display("FAIL sb_err_set: got %0b want 1", sb_err); else n_pass++;
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0); pre(); post();
    n_chk++; if (sb_err !== 1'b1) $display("FAIL sb_err_sticky: got %0b want 1", sb_err); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL x0_untracked: busy got %0b want 0", busy); else n_pass++;
    @(negedge clk); drive(1, 0, 1, 0, 1, 12, 1, 0, 1, 0, 0, 0, 0); pre();
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL x0_read: got %0b want 1", issue_ready); else n_pass++;
    post();
    drain_all();
  endtask

  task automatic test_random();
    int pend [$];
    int wr;
    bit wv;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      pend.delete();
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) pend.push_back(r);
      wv = (pend.size() > 0) && ($urandom_range(0, 9) < 4);
      wr = wv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
            wv, wr, (mst == 2) && ($urandom_range(0, 4) == 0), $urandom_range(0, 19) == 0);
      pre();
      n_chk++; if (issue_ready !== exp_ready) $display("FAIL rnd_ready c%0d: got %0b want %0b", c, issue_ready, exp_ready); else n_pass++;
      n_chk++; if (issue_fire !== exp_fire) $display("FAIL rnd_fire c%0d: got %0b want %0b", c, issue_fire, exp_fire); else n_pass++;
      post();
      n_chk++; if (busy !== exp_busy) $display("FAIL rnd_busy c%0d: got %0b want %0b", c, busy, exp_busy); else n_pass++;
      n_chk++; if (sb_err !== merr) $display("FAIL rnd_sb_err c%0d: got %0b want %0b", c, sb_err, merr); else n_pass++;
    end
    drain_all();
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0); pre(); post();
    end
    n_chk++; if (busy !== 1'b1) $display("FAIL ar_serial_busy: got %0b want 1", busy); else n_pass++;
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    pre();
    n_chk++; if (issue_ready !== 1'b0) $display("FAIL ar_pre_ready: got %0b want 0", issue_ready); else n_pass++;
    #1 rst = 1'b1;
    m_reset();
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL ar_busy: got %0b want 0", busy); else n_pass++;
    n_chk++; if (sb_err !== 1'b0) $display("FAIL ar_sb_err: got %0b want 0", sb_err); else n_pass++;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL ar_ready: got %0b want 1", issue_ready); else n_pass++;
    @(negedge clk); rst = 1'b0;
    drive(1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0);
    pre();
    n_chk++; if (issue_fire !== 1'b1) $display("FAIL ar_after_fire: got %0b want 1", issue_fire); else n_pass++;
    post();
    drain_all();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_overflow();
    test_serial();
    test_flush();
    test_err_x0();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
